// File: rtl/qsys_gpio_pkg.sv
// Shared register offsets and edge-select encodings for the Avalon-MM GPIO slave.
package qsys_gpio_pkg;

    localparam logic [2:0] ADDR_DATA = 3'd0;
    localparam logic [2:0] ADDR_DIR  = 3'd1;
    localparam logic [2:0] ADDR_MASK = 3'd2;
    localparam logic [2:0] ADDR_EDGE = 3'd3;
    localparam logic [2:0] ADDR_OSET = 3'd4;
    localparam logic [2:0] ADDR_OCLR = 3'd5;

    localparam int unsigned EDGE_RISE = 0;
    localparam int unsigned EDGE_FALL = 1;
    localparam int unsigned EDGE_ANY  = 2;

endpackage

// File: rtl/qsys_gpio_if.sv
// Avalon-MM slave port bundle: 3-bit word address, 32-bit data, readLatency=1.
interface qsys_gpio_if;

    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );

endinterface

// File: rtl/qsys_gpio_sync_edge.sv
// Input synchroniser chain plus one history flop; emits in_sync and a per-bit edge pulse.
module qsys_gpio_sync_edge
    import qsys_gpio_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port_i,
    output logic [WIDTH-1:0] in_sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= in_port_i;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign in_sync_o = sync_q[SYNC_STAGES-1];

    always_comb begin
        edge_o = '0;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_o = in_sync_o & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_o = ~in_sync_o & prev_q;
        end else begin
            edge_o = in_sync_o ^ prev_q;
        end
    end

endmodule

// File: rtl/qsys_design_gpio_pio.sv
// Avalon-MM GPIO slave: register file, atomic set/clear, read mux, edge capture and masked irq.
module qsys_design_gpio_pio
    import qsys_gpio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] RESET_DIR   = '1,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    qsys_gpio_if.slave       avs,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] dir_q, dir_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] clr, wd, rd_sel, in_sync, edge_pulse;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             wr;
    logic             unused_wd;

    assign wr        = avs.chipselect & ~avs.write_n;
    assign wd        = avs.writedata[WIDTH-1:0];
    assign unused_wd = ^avs.writedata;

    qsys_gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk       (clk),
        .reset     (reset),
        .in_port_i (in_port),
        .in_sync_o (in_sync),
        .edge_o    (edge_pulse)
    );

    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        mask_d = mask_q;
        clr    = '0;
        if (wr) begin
            case (avs.address)
                ADDR_DATA: data_d = wd;
                ADDR_DIR:  dir_d  = wd;
                ADDR_MASK: mask_d = wd;
                ADDR_EDGE: clr    = wd;
                ADDR_OSET: data_d = data_q | wd;
                ADDR_OCLR: data_d = data_q & ~wd;
                default:   ;
            endcase
        end
        // A fresh edge overrides a simultaneous W1C of the same bit.
        cap_d = (cap_q & ~clr) | edge_pulse;
        irq_d = |(cap_q & mask_q);
    end

    always_comb begin
        rd_sel = '0;
        case (avs.address)
            ADDR_DATA: rd_sel = (dir_q & data_q) | (~dir_q & in_sync);
            ADDR_DIR:  rd_sel = dir_q;
            ADDR_MASK: rd_sel = mask_q;
            ADDR_EDGE: rd_sel = cap_q;
            default:   rd_sel = '0;
        endcase
        readdata_d              = '0;
        readdata_d[WIDTH-1:0]   = rd_sel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            dir_q      <= RESET_DIR;
            mask_q     <= '0;
            cap_q      <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            dir_q      <= dir_d;
            mask_q     <= mask_d;
            cap_q      <= cap_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign avs.readdata = readdata_q;
    assign out_port     = data_q;
    assign oe_port      = dir_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_qsys_design_gpio_pio.sv
// Directed and randomized checks of the GPIO slave against a behavioural register-map model.
module tb_qsys_design_gpio_pio;
    import qsys_gpio_pkg::*;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_port = 8'h00;
    wire  [7:0] out_port;
    wire  [7:0] oe_port;
    wire        irq;

    int total = 0;
    int bad   = 0;

    qsys_gpio_if bus ();

    qsys_design_gpio_pio #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00),
        .RESET_DIR   (8'hFF),
        .EDGE_TYPE   (EDGE_RISE),
        .SYNC_STAGES (SS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .avs      (bus.slave),
        .in_port  (in_port),
        .out_port (out_port),
        .oe_port  (oe_port),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Reference model: architectural registers plus a history of sampled pins (newest first).
    logic [7:0]  m_data, m_dir, m_mask, m_cap;
    logic        m_irq;
    logic [31:0] m_rd;
    logic [7:0]  hist[$];

    task automatic model_reset();
        m_data = 8'h00; m_dir = 8'hFF; m_mask = 8'h00; m_cap = 8'h00;
        m_irq = 1'b0; m_rd = 32'h0;
        hist.delete();
        for (int i = 0; i <= SS; i++) hist.push_back(8'h00);
    endtask

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic step();
        logic [7:0]  ins, prv, edg, wd, clr, nd, ndir, nm, ncap;
        logic [31:0] nrd;
        logic        nirq, wr;
        ins  = hist[SS-1];
        prv  = hist[SS];
        edg  = ins & ~prv;
        wr   = bus.chipselect && !bus.write_n;
        wd   = bus.writedata[7:0];
        nd   = m_data; ndir = m_dir; nm = m_mask; clr = 8'h00;
        if (wr) begin
            if (bus.address == 3'd0) nd = wd;
            if (bus.address == 3'd1) ndir = wd;
            if (bus.address == 3'd2) nm = wd;
            if (bus.address == 3'd3) clr = wd;
            if (bus.address == 3'd4) nd = m_data | wd;
            if (bus.address == 3'd5) nd = m_data & ~wd;
        end
        ncap = (m_cap & ~clr) | edg;
        nirq = (m_cap & m_mask) != 8'h00;
        nrd  = 32'h0;
        if (bus.address == 3'd0) nrd = {24'h0, (m_dir & m_data) | (~m_dir & ins)};
        if (bus.address == 3'd1) nrd = {24'h0, m_dir};
        if (bus.address == 3'd2) nrd = {24'h0, m_mask};
        if (bus.address == 3'd3) nrd = {24'h0, m_cap};
        @(posedge clk);
        #1;
        if (reset) begin
            model_reset();
        end else begin
            m_data = nd; m_dir = ndir; m_mask = nm; m_cap = ncap; m_irq = nirq; m_rd = nrd;
            hist.push_front(in_port);
            void'(hist.pop_back());
        end
    endtask

    task automatic idle();
        bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 3'd7; bus.writedata = 32'h0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
        step();
        idle();
    endtask

    task automatic rd(input logic [2:0] a);
        bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = a; bus.writedata = 32'h0;
        step();
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        idle();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        total++;
        if (out_port !== 8'h00 || oe_port !== 8'hFF || irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h oe=%h irq=%b, want out=00 oe=ff irq=0",
                     out_port, oe_port, irq);
        end
        for (int a = 0; a < 8; a++) begin
            rd(3'(a));
            exp = (a == 1) ? 32'h0000_00FF : 32'h0;
            total++;
            if (bus.readdata !== exp) begin
                bad++;
                $display("FAIL reset_read[%0d]: got %h want %h", a, bus.readdata, exp);
            end
        end
    endtask

    task automatic test_set_clr();
        logic [7:0] want[3];
        logic [2:0] addr[3];
        logic [7:0] dat[3];
        want = '{8'h5A, 8'hDB, 8'hC3};
        addr = '{ADDR_DATA, ADDR_OSET, ADDR_OCLR};
        dat  = '{8'h5A, 8'h81, 8'h18};
        for (int i = 0; i < 3; i++) begin
            bus.chipselect = 1'b1; bus.write_n = 1'b0;
            bus.address = addr[i]; bus.writedata = {24'hFFFFFF, dat[i]};
            step();
            total++;
            if (out_port !== want[i]) begin
                bad++;
                $display("FAIL set_clr[%0d]: out_port got %h want %h", i, out_port, want[i]);
            end
        end
        idle();
        rd(ADDR_DATA);
        total++;
        if (bus.readdata !== 32'h0000_00C3) begin
            bad++;
            $display("FAIL set_clr_read: got %h want 000000c3", bus.readdata);
        end
    endtask

    task automatic test_input_mux();
        wr(ADDR_DIR, 32'h0F);
        wr(ADDR_DATA, 32'h05);
        in_port = 8'hA0;
        step(); step();
        rd(ADDR_DATA);
        total++;
        if (bus.readdata !== 32'h0000_00A5) begin
            bad++;
            $display("FAIL input_mux_a5: got %h want 000000a5", bus.readdata);
        end
        in_port = 8'h20;
        step(); step();
        rd(ADDR_DATA);
        total++;
        if (bus.readdata !== 32'h0000_0025) begin
            bad++;
            $display("FAIL input_mux_25: got %h want 00000025", bus.readdata);
        end
    endtask

    task automatic test_edge_irq();
        in_port = 8'h00;
        step(); step(); step();
        wr(ADDR_EDGE, 32'hFF);
        wr(ADDR_MASK, 32'h01);
        in_port = 8'h01;
        step();
        in_port = 8'h00;
        step(); step();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_early: irq got %b want 0 three cycles after pin", irq);
        end
        step();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_rise: irq got %b want 1 four cycles after pin", irq);
        end
        step(); step(); step();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_hold: irq got %b want 1 after pulse ended", irq);
        end
        rd(ADDR_EDGE);
        total++;
        if (bus.readdata !== 32'h01) begin
            bad++;
            $display("FAIL edge_read: got %h want 00000001", bus.readdata);
        end
        wr(ADDR_EDGE, 32'h01);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL irq_clr_edge: irq got %b want 1 on the clearing edge", irq);
        end
        step();
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL irq_fall: irq got %b want 0 one cycle after clear", irq);
        end
    endtask

    task automatic test_set_wins();
        in_port = 8'h04;
        step(); step(); step();
        in_port = 8'h00;
        step(); step(); step();
        rd(ADDR_EDGE);
        total++;
        if (bus.readdata !== 32'h04) begin
            bad++;
            $display("FAIL set_wins_pre: EDGE got %h want 00000004", bus.readdata);
        end
        in_port = 8'h04;
        step(); step();
        wr(ADDR_EDGE, 32'h04);
        rd(ADDR_EDGE);
        total++;
        if (bus.readdata !== 32'h04) begin
            bad++;
            $display("FAIL set_wins: EDGE got %h want 00000004", bus.readdata);
        end
        wr(ADDR_EDGE, 32'h04);
        rd(ADDR_EDGE);
        total++;
        if (bus.readdata !== 32'h00) begin
            bad++;
            $display("FAIL set_wins_clear: EDGE got %h want 00000000", bus.readdata);
        end
    endtask

    task automatic test_reset_mid();
        wr(ADDR_MASK, 32'hFF);
        in_port = 8'h14;
        step(); step(); step(); step();
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_pre: irq got %b want 1", irq);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if (irq !== 1'b0 || out_port !== 8'h00 || oe_port !== 8'hFF) begin
            bad++;
            $display("FAIL reset_mid_out: irq=%b out=%h oe=%h want irq=0 out=00 oe=ff",
                     irq, out_port, oe_port);
        end
        rd(ADDR_EDGE);
        total++;
        if (bus.readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_edge: got %h want 00000000", bus.readdata);
        end
        rd(ADDR_MASK);
        total++;
        if (bus.readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_mid_mask: got %h want 00000000", bus.readdata);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            bus.address    = 3'($urandom_range(0, 7));
            bus.chipselect = ($urandom_range(0, 3) != 0);
            bus.write_n    = ($urandom_range(0, 1) != 0);
            bus.writedata  = $urandom;
            in_port        = ($urandom_range(0, 3) == 0) ? 8'($urandom) : in_port;
            reset          = ($urandom_range(0, 99) == 0);
            step();
            total++;
            if (out_port !== m_data || oe_port !== m_dir || irq !== m_irq ||
                bus.readdata !== m_rd) begin
                bad++;
                $display("FAIL random[%0d]: out=%h/%h oe=%h/%h irq=%b/%b rd=%h/%h (got/want)",
                         n, out_port, m_data, oe_port, m_dir, irq, m_irq, bus.readdata, m_rd);
            end
        end
        reset = 1'b0;
        idle();
    endtask

    initial begin
        model_reset();
        test_reset();
        test_set_clr();
        test_input_mux();
        test_edge_irq();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
